// File: rtl/normalizer.sv
// normalizer -- multi-cycle left-normalizer for the 16-bit datapath.
//
// Finds the left-shift count that brings an operand to normal form.
// In unsigned mode that form has bit15 set. In signed mode it has
// bit15 != bit14. The block returns the normalized value and the count.
// Feeding the count back to the barrel shifter as a right shift undoes
// the normalization.
//
// Optional feature: define NORMALIZER_NIBBLE_STEP_EN to take 4-bit steps
// whenever they cannot overshoot the stop point. The final result and
// count match the default build; only the latency is shorter.
module normalizer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] v,
    input  logic        signed_mode,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic [4:0]  count,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] work, work_next;
    logic [4:0]  cnt, cnt_next;
    logic        zero_q, zero_next;
    logic        smode, smode_next;
    logic        stop;
    logic        nibble_ok;

    // Stop once the working value is normal or the count reaches its mode limit.
    always_comb begin
        if (smode) begin
            stop = (work[15] != work[14]) || (cnt == 5'd15);
        end else begin
            stop = work[15] || (cnt == 5'd16);
        end
    end

    // A 4-bit step is safe when none of the shifted-out bits could have stopped us earlier.
    always_comb begin
`ifdef NORMALIZER_NIBBLE_STEP_EN
        if (smode) begin
            nibble_ok = ((work[15:11] == 5'b00000) || (work[15:11] == 5'b11111))
                        && (cnt <= 5'd11);
        end else begin
            nibble_ok = (work[15:12] == 4'h0) && (cnt <= 5'd12);
        end
`else
        nibble_ok = 1'b0;
`endif
    end

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves it unassigned and no latch is inferred.
        state_next = state;
        work_next  = work;
        cnt_next   = cnt;
        zero_next  = zero_q;
        smode_next = smode;
        case (state)
            IDLE: begin
                if (start) begin
                    work_next  = v;
                    cnt_next   = 5'd0;
                    zero_next  = (v == 16'h0000);
                    smode_next = signed_mode;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_next = DONE;
                end else if (nibble_ok) begin
                    work_next = {work[11:0], 4'h0};
                    cnt_next  = cnt + 5'd4;
                end else begin
                    work_next = {work[14:0], 1'b0};
                    cnt_next  = cnt + 5'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            work   <= 16'h0000;
            cnt    <= 5'd0;
            zero_q <= 1'b0;
            smode  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state  <= state_next;
            work   <= work_next;
            cnt    <= cnt_next;
            zero_q <= zero_next;
            smode  <= smode_next;
        end
    end

    // Outputs are decoded only from registers, so no input reaches an output combinationally.
    assign ready  = (state == IDLE);
    assign done   = (state == DONE);
    assign result = work;
    assign count  = cnt;
    assign zero   = zero_q;

endmodule

// File: tb/tb_normalizer.sv
// tb_normalizer -- directed, table-driven bench for normalizer.
// The expected latency column is selected by NORMALIZER_NIBBLE_STEP_EN,
// so the same bench covers both builds.
module tb_normalizer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] v;
    logic        signed_mode;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic [4:0]  count;
    logic        zero;

    int checks;
    int errors;

    normalizer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .v           (v),
        .signed_mode (signed_mode),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .count       (count),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        logic        sm;
        logic [15:0] exp_result;
        logic [4:0]  exp_count;
        logic        exp_zero;
        int          edges_plain;   // edge index of DONE entry, 1-bit steps only
        int          edges_nibble;  // same, with 4-bit steps enabled
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one request; return outputs captured in the done cycle and
    // the edge index (counted from E0) after which done was first seen.
    task automatic run_op(input logic [15:0] val, input logic sm,
                          output logic [15:0] r, output logic [4:0] c,
                          output logic z, output int edges);
        start = 1'b1;
        v = val;
        signed_mode = sm;
        @(posedge clk);
        #1;
        start = 1'b0;
        v = 16'hDEAD;
        signed_mode = ~sm;
        edges = 0;
        r = 16'h0;
        c = 5'h0;
        z = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = k;
                r = result;
                c = count;
                z = zero;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] r;
        logic [4:0]  c;
        logic        z;
        int          edges;
        int          exp_edges;
        int          done_seen;

        checks = 0;
        errors = 0;
        start = 1'b0;
        v = 16'h0;
        signed_mode = 1'b0;
        reset_n = 1'b0;

        vecs[0] = '{16'h8000, 1'b0, 16'h8000, 5'd0,  1'b0, 1,  1};
        vecs[1] = '{16'h0001, 1'b0, 16'h8000, 5'd15, 1'b0, 16, 7};
        vecs[2] = '{16'h0000, 1'b0, 16'h0000, 5'd16, 1'b1, 17, 5};
        vecs[3] = '{16'h4000, 1'b0, 16'h8000, 5'd1,  1'b0, 2,  2};
        vecs[4] = '{16'h1234, 1'b0, 16'h91A0, 5'd3,  1'b0, 4,  4};
        vecs[5] = '{16'hFFF0, 1'b1, 16'h8000, 5'd11, 1'b0, 12, 6};
        vecs[6] = '{16'h0003, 1'b1, 16'h6000, 5'd13, 1'b0, 14, 5};
        vecs[7] = '{16'hFFFF, 1'b1, 16'h8000, 5'd15, 1'b0, 16, 7};
        vecs[8] = '{16'h0000, 1'b1, 16'h0000, 5'd15, 1'b1, 16, 7};
        vecs[9] = '{16'h4000, 1'b1, 16'h4000, 5'd0,  1'b0, 1,  1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready",  {31'b0, ready},  32'd1);
        check("reset_done",   {31'b0, done},   32'd0);
        check("reset_result", {16'b0, result}, 32'h0);
        check("reset_count",  {27'b0, count},  32'd0);
        check("reset_zero",   {31'b0, zero},   32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors
        foreach (vecs[i]) begin
`ifdef NORMALIZER_NIBBLE_STEP_EN
            exp_edges = vecs[i].edges_nibble;
`else
            exp_edges = vecs[i].edges_plain;
`endif
            run_op(vecs[i].v, vecs[i].sm, r, c, z, edges);
            check($sformatf("v%0d_result", i),  {16'b0, r}, {16'b0, vecs[i].exp_result});
            check($sformatf("v%0d_count", i),   {27'b0, c}, {27'b0, vecs[i].exp_count});
            check($sformatf("v%0d_zero", i),    {31'b0, z}, {31'b0, vecs[i].exp_zero});
            check($sformatf("v%0d_latency", i), edges, exp_edges);
            check($sformatf("v%0d_busy", i),    {31'b0, ready}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready_after", i), {31'b0, ready}, 32'd1);
            check($sformatf("v%0d_done_pulse", i),  {31'b0, done},  32'd0);
            check($sformatf("v%0d_hold_count", i),  {27'b0, count}, {27'b0, vecs[i].exp_count});
        end

        // Busy: a second start during SHIFT is dropped
        start = 1'b1;
        v = 16'h0001;
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        v = 16'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_seen = 0;
        c = 5'h0;
        r = 16'h0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                done_seen++;
                c = count;
                r = result;
            end
            @(posedge clk);
            #1;
        end
        check("busy_done_count", done_seen, 1);
        check("busy_count",  {27'b0, c}, 32'd15);
        check("busy_result", {16'b0, r}, 32'h8000);

        // Reset mid-operation
        start = 1'b1;
        v = 16'h0001;
        signed_mode = 1'b0;
        @(posedge clk);          // E0
        #1;
        start = 1'b0;
        @(posedge clk);          // E1
        @(posedge clk);          // E2
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_ready",  {31'b0, ready},  32'd1);
        check("midrst_done",   {31'b0, done},   32'd0);
        check("midrst_result", {16'b0, result}, 32'h0);
        check("midrst_count",  {27'b0, count},  32'd0);
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run_op(16'h4000, 1'b0, r, c, z, edges);
        check("postrst_count",  {27'b0, c}, 32'd1);
        check("postrst_result", {16'b0, r}, 32'h8000);
        check("postrst_latency", edges, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/normalizer.md
# normalizer

Multi-cycle left-normalizer for the 16-bit datapath; the inverse of the barrel shifter. Given an operand, it finds the left-shift count that brings the value to normal form and returns both the normalized value and that count. Feeding the count back to the shifter as `by` with a right shift undoes the normalization. It sits beside the ALU and serves count-leading-zeros/sign and normalize instructions through a start/ready/done handshake.

## Interface
- No parameters; data width fixed at 16.
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `v`  in  16  operand, sampled on the accepting edge.
- `signed_mode`  in  1  sampled with `v`:
  - 0 = unsigned: normalize until bit15=1.
  - 1 = signed: normalize until bit15≠bit14.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse when `result`/`count` become valid.
- `result`  out  16  normalized value.
- `count`  out  5  left shifts applied, range 0..16.
- `zero`  out  1  latched operand was 0x0000.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `ready`=1.
  - On `start`: load `v` into the working register, latch `signed_mode`, set `count`=0, set `zero`=(v==0), go to SHIFT.
- SHIFT, evaluated every edge:
  - Stop condition (unsigned): work[15]=1 or count=16.
  - Stop condition (signed): work[15]≠work[14] or count=15.
  - If stop holds, go to DONE. Otherwise work ← work<<1 (zero fill) and count ← count+1.
- DONE:
  - `done`=1 for exactly one cycle, `ready`=0.
  - Next edge returns to IDLE.
- `result`, `count`, `zero` hold from DONE until the next accepted `start`.
  - `result` equals the working register at all times.
- `start` while `ready`=0 is ignored, with no queuing.
- Boundary cases:
  - Unsigned 0x0000: count=16, result=0x0000, zero=1.
  - Signed 0x0000: count=15, result=0x0000, zero=1.
  - Signed 0xFFFF: count=15, result=0x8000, zero=0.
- Reset asserted mid-operation aborts immediately to IDLE. Any in-flight result is lost and no `done` is produced.

## Timing
- Reset values: `ready`=1, `done`=0, `result`=0x0000, `count`=0, `zero`=0, state IDLE.
- Call the accepting edge E0. With N shift steps needed:
  - E1..EN perform shifts.
  - E(N+1) enters DONE, so `done` is high in the cycle after E(N+1).
  - E(N+2) returns to IDLE, so `ready` is high again after E(N+2).
- Latency from `start` to `done` is N+2 edges; minimum 2 (N=0).
- A new `start` is accepted in the first IDLE cycle. Back-to-back throughput is therefore N+3 cycles per operation.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `NORMALIZER_NIBBLE_STEP_EN`
  - Defined: while in SHIFT and the stop condition is false, a 4-bit step replaces the 1-bit step when it is safe:
    - Unsigned: work[15:12]=0 and count≤12.
    - Signed: work[15:11] all equal and count≤11.
    - The step does work ← work<<4 and count ← count+4.
  - Final `result`/`count` are identical to the undefined build; only N (and latency) shrinks.
  - Undefined: 1-bit steps only.

## Test plan
- Unsigned v=0x8000:
  - count=0, result=0x8000, zero=0.
  - `done` in the cycle after E1; `ready` after E2.
- Unsigned v=0x0001:
  - count=15, result=0x8000.
  - `done` after E16 without the macro; after E7 with the macro (steps 4,4,4,1,1,1).
- Unsigned v=0x0000:
  - count=16, result=0x0000, zero=1.
  - `done` after E17 without the macro; after E5 with it.
- Signed cases:
  - v=0xFFF0: count=11, result=0x8000.
  - v=0x0003: count=13, result=0x6000.
  - v=0xFFFF: count=15, result=0x8000, zero=0.
- Busy behaviour: pulse `start` with v=0x1234 during SHIFT of v=0x0001. The second request is ignored; exactly one `done`, for the first operand (count=15).
- Reset mid-operation: assert `reset_n`=0 at E3 of v=0x0001.
  - Outputs return to reset values immediately, with no `done` pulse.
  - A subsequent `start` with v=0x4000 yields count=1, result=0x8000.
